// File: rtl/mdu_pkg.sv
// Shared encodings and latency constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL1 = 3'd1,
    ST_MUL2 = 3'd2,
    ST_DIVI = 3'd3,
    ST_DIVF = 3'd4
  } state_t;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned DIV_LAT = 33;

endpackage

// File: rtl/div_seq.sv
// Sequential restoring radix-2 divider with signed magnitude conversion and
// sign fixup. done flags the final iteration cycle; q/r are valid the cycle after.
module div_seq
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LAT - 2);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] a_raw;
  logic             q_neg;
  logic             r_neg;
  logic             dbz;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Operand magnitudes and one restoring trial subtraction.
  always_comb begin
    a_neg   = is_signed & a[WIDTH-1];
    b_neg   = is_signed & b[WIDTH-1];
    a_mag   = a_neg ? (~a) + WIDTH'(1) : a;
    b_mag   = b_neg ? (~b) + WIDTH'(1) : b;
    shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
  end

  // Setup on start, then one quotient bit per cycle until the counter hits 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      a_raw   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dbz     <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CNT_INIT;
      rem     <= '0;
      quo     <= a_mag;
      dvs     <= b_mag;
      a_raw   <= a;
      q_neg   <= a_neg ^ b_neg;
      r_neg   <= a_neg;
      dbz     <= (b == '0);
    end else if (running) begin
      rem <= diff[WIDTH] ? shifted : diff;
      quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
      if (cnt == '0) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Final iteration indicator and sign-corrected results; divide by zero is
  // forced to all-ones quotient and the raw dividend as remainder.
  always_comb begin
    done = running && (cnt == '0);
    if (dbz) begin
      q = '1;
      r = a_raw;
    end else begin
      q = q_neg ? (~quo) + WIDTH'(1) : quo;
      r = r_neg ? (~rem[WIDTH-1:0]) + WIDTH'(1) : rem[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult.sv
// 32x32 signed combinational multiplier, full 64-bit product.
module mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;

  // Sign-extend both operands so the 64-bit product is the signed result.
  always_comb begin
    a_ext = {{32{a[31]}}, a};
    b_ext = {{32{b[31]}}, b};
    p     = a_ext * b_ext;
  end

endmodule

// File: rtl/hilo_mdu.sv
// MIPS HI/LO multiply/divide unit: two-cycle registered multiply with MULTU
// correction, 33-cycle sequential divide, MTHI/MTLO, flush and busy/done.
module hilo_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t state;
  state_t state_nxt;

  logic ld_mul;
  logic wr_mul;
  logic wr_div;
  logic wr_mthi;
  logic wr_mtlo;
  logic div_start;
  logic div_done;

  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               u_q;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   hi_corr;

  mult u_mult (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  div_seq #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .a         (rs_val),
    .b         (rt_val),
    .is_signed (op == OP_DIV),
    .done      (div_done),
    .q         (div_q),
    .r         (div_r)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control strobes; flush cancels both accepts and writes.
  always_comb begin
    state_nxt = state;
    ld_mul    = 1'b0;
    wr_mul    = 1'b0;
    wr_div    = 1'b0;
    wr_mthi   = 1'b0;
    wr_mtlo   = 1'b0;
    div_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (op_valid && !flush) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              ld_mul    = 1'b1;
              state_nxt = ST_MUL1;
            end
            OP_DIV, OP_DIVU: begin
              div_start = 1'b1;
              state_nxt = ST_DIVI;
            end
            OP_MTHI: wr_mthi = 1'b1;
            OP_MTLO: wr_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL1: state_nxt = flush ? ST_IDLE : ST_MUL2;
      ST_MUL2: begin
        state_nxt = ST_IDLE;
        wr_mul    = !flush;
      end
      ST_DIVI: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (div_done) begin
          state_nxt = ST_DIVF;
        end
      end
      ST_DIVF: begin
        state_nxt = ST_IDLE;
        wr_div    = !flush;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Multiplier operand and product pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      u_q    <= 1'b0;
      prod_q <= '0;
    end else begin
      if (ld_mul) begin
        a_q <= rs_val;
        b_q <= rt_val;
        u_q <= (op == OP_MULTU);
      end
      if (state == ST_MUL1) begin
        prod_q <= prod;
      end
    end
  end

  // Unsigned correction only touches the upper half (mod 2^64).
  always_comb begin
    hi_corr = prod_q[2*WIDTH-1:WIDTH]
            + ((u_q && a_q[WIDTH-1]) ? b_q : '0)
            + ((u_q && b_q[WIDTH-1]) ? a_q : '0);
  end

  // Architectural HI/LO and the write-edge done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= wr_mul | wr_div;
      if (wr_mul) begin
        hi <= hi_corr;
        lo <= prod_q[WIDTH-1:0];
      end else if (wr_div) begin
        hi <= div_r;
        lo <= div_q;
      end else if (wr_mthi) begin
        hi <= rs_val;
      end else if (wr_mtlo) begin
        lo <= rs_val;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed self-checking bench for hilo_mdu.
module tb_hilo_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hilo_mdu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one op, then measure busy length and done pulses and check HI/LO.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int lat,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    int dn;
    @(negedge clk);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0;
    n  = 0;
    dn = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
      if (done) dn++;
    end
    check({tag, " busy_cycles"}, 32'(n), 32'(lat));
    check({tag, " done_count"}, 32'(dn), (lat > 0) ? 32'd1 : 32'd0);
    check({tag, " done_at_end"}, 32'(done), (lat > 0) ? 32'd1 : 32'd0);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dn;

    #12;
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("mult_neg",    3'd1, 32'hFFFFFFFD, 32'd7,        2,  32'hFFFFFFFF, 32'hFFFFFFEB);
    do_op("multu_ones",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,  32'hFFFFFFFE, 32'h00000001);
    do_op("mult_ones",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,  32'h00000000, 32'h00000001);
    do_op("multu_msb",   3'd2, 32'h80000000, 32'd2,        2,  32'h00000001, 32'h00000000);
    do_op("div_neg7_2",  3'd3, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("div_7_neg2",  3'd3, 32'd7,        32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD);
    do_op("divu_100_7",  3'd4, 32'd100,      32'd7,        33, 32'd2,        32'd14);
    do_op("divu_by0",    3'd4, 32'h1234,     32'd0,        33, 32'h1234,     32'hFFFFFFFF);
    do_op("div_by0",     3'd3, 32'h1234,     32'd0,        33, 32'h1234,     32'hFFFFFFFF);
    do_op("div_neg_by0", 3'd3, 32'h80000005, 32'd0,        33, 32'h80000005, 32'hFFFFFFFF);
    do_op("div_ovf",     3'd3, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000);
    do_op("mthi",        3'd5, 32'h1111,     32'd0,        0,  32'h1111,     32'h80000000);
    do_op("mtlo",        3'd6, 32'h2222,     32'd0,        0,  32'h1111,     32'h2222);
    do_op("nop7",        3'd7, 32'hDEAD,     32'hBEEF,     0,  32'h1111,     32'h2222);

    // MTHI held while a divide is busy, then flush at iteration 10.
    @(negedge clk);
    op_valid = 1'b1; op = 3'd4; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk);
    @(negedge clk);
    op = 3'd5; rs_val = 32'hAAAA;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("busy_before_flush", 32'(busy), 32'd1);
    check("mthi_ignored", hi, 32'h1111);
    op_valid = 1'b0; op = 3'd0; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush done", 32'(done), 32'd0);
    check("flush hi", hi, 32'h1111);
    check("flush lo", lo, 32'h2222);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("flush no_done_later", 32'(dn), 32'd0);
    check("flush hi_later", hi, 32'h1111);
    check("flush lo_later", lo, 32'h2222);

    // Flush on an accept edge cancels MTLO and MULT.
    @(negedge clk);
    op_valid = 1'b1; op = 3'd6; rs_val = 32'h99; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("acc_flush mtlo", lo, 32'h2222);
    op = 3'd1; rs_val = 32'd3; rt_val = 32'd4;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0; flush = 1'b0;
    check("acc_flush mult busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    op_valid = 1'b1; op = 3'd1; rs_val = 32'd5; rt_val = 32'd6;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0;
    check("pre_reset busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst hi", hi, 32'h0);
    check("async_rst lo", lo, 32'h0);
    check("async_rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op_valid = 1'b1; op = 3'd6; rs_val = 32'h55;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0;
    check("mtlo_after_rst lo", lo, 32'h55);
    check("mtlo_after_rst hi", hi, 32'h0);
    check("mtlo_after_rst busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
